// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: command codes, sequencer states and RGB565 colour-bar palette.
package pattern_gen_pkg;
  typedef enum logic [1:0] {
    CMD_NONE        = 2'd0,
    CMD_FRAME_START = 2'd1,
    CMD_PIXEL_WORD  = 2'd2,
    CMD_FRAME_END   = 2'd3
  } cmd_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_PIXELS, S_END, S_GAP} state_e;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] BAR_PALETTE [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
endpackage

// File: rtl/pattern_bar_palette.sv
// pattern_bar_palette: registered bar-index to RGB565 lookup, white when marker is set.
module pattern_bar_palette
  import pattern_gen_pkg::*;
(
  input  logic        clk_cam,
  input  logic        reset_n,
  input  logic [2:0]  bar_idx,
  input  logic        marker,
  output logic [15:0] color
);
  always_ff @(posedge clk_cam or negedge reset_n)
    if (!reset_n) color <= '0;
    else color <= marker ? RGB_WHITE : BAR_PALETTE[bar_idx];
endmodule

// File: rtl/pattern_frame_sequencer.sv
// pattern_frame_sequencer: framed colour-bar command stream with valid/ready pacing and inter-frame gap.
module pattern_frame_sequencer
  import pattern_gen_pkg::*;
#(
  parameter int FRAME_WIDTH      = 640,
  parameter int FRAME_HEIGHT     = 480,
  parameter int BAR_COUNT        = 8,
  parameter int FRAME_GAP_CYCLES = 1024
) (
  input  logic        clk_cam,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_code,
  output logic [31:0] pixel_data,
  output logic [15:0] frame_count,
  output logic        busy
);
  localparam int WORDS     = FRAME_WIDTH / 2;
  localparam int BAR_WORDS = FRAME_WIDTH / BAR_COUNT / 2;
  localparam int XW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int LW = FRAME_HEIGHT > 1 ? $clog2(FRAME_HEIGHT) : 1;
  localparam int SW = BAR_WORDS > 1 ? $clog2(BAR_WORDS) : 1;
  localparam int GW = FRAME_GAP_CYCLES > 1 ? $clog2(FRAME_GAP_CYCLES) : 1;
  state_e state, state_n;
  logic [XW-1:0] x_word, x_word_n;
  logic [LW-1:0] line, line_n;
  logic [SW-1:0] sub, sub_n;
  logic [2:0] bar, bar_n;
  logic [GW-1:0] gap_cnt;
  logic [15:0] color;
  logic xfer, pix_xfer, last_x, last_word, bar_end;
  assign cmd_valid  = state inside {S_START, S_PIXELS, S_END};
  assign busy       = state != S_IDLE;
  assign xfer       = cmd_valid & cmd_ready;
  assign pix_xfer   = xfer && state == S_PIXELS;
  assign last_x     = x_word == XW'(WORDS - 1);
  assign last_word  = last_x && line == LW'(FRAME_HEIGHT - 1);
  assign bar_end    = sub == SW'(BAR_WORDS - 1);
  assign cmd_code   = state == S_START ? CMD_FRAME_START : state == S_PIXELS ? CMD_PIXEL_WORD :
                      state == S_END ? CMD_FRAME_END : CMD_NONE;
  assign pixel_data = state == S_PIXELS ? {color, color} : state == S_END ? {16'd0, frame_count} : '0;
  always_comb begin
    x_word_n = pix_xfer ? (last_x ? '0 : x_word + 1'b1) : x_word;
    line_n   = pix_xfer && last_x ? (last_word ? '0 : line + 1'b1) : line;
    sub_n    = pix_xfer ? (last_x || bar_end ? '0 : sub + 1'b1) : sub;
    bar_n    = pix_xfer ? (last_x ? '0 : bar_end ? bar + 3'd1 : bar) : bar;
    state_n  = state;
    unique case (state)
      S_IDLE:   state_n = enable ? S_START : S_IDLE;
      S_START:  state_n = xfer ? S_PIXELS : S_START;
      S_PIXELS: state_n = xfer && last_word ? S_END : S_PIXELS;
      S_END:    state_n = xfer ? S_GAP : S_END;
      S_GAP:    state_n = gap_cnt != '0 ? S_GAP : enable ? S_START : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end
  // The palette sees next-cycle counters so its registered colour lines up with the presented word.
  pattern_bar_palette u_palette (
    .clk_cam (clk_cam),
    .reset_n (reset_n),
    .bar_idx (bar_n),
    .marker  (frame_count[0] && line_n == '0),
    .color   (color)
  );
  always_ff @(posedge clk_cam or negedge reset_n)
    if (!reset_n) begin
      state       <= S_IDLE;
      x_word      <= '0;
      line        <= '0;
      sub         <= '0;
      bar         <= '0;
      gap_cnt     <= '0;
      frame_count <= '0;
    end else begin
      state  <= state_n;
      x_word <= x_word_n;
      line   <= line_n;
      sub    <= sub_n;
      bar    <= bar_n;
      if (xfer && state == S_END) begin
        frame_count <= frame_count + 16'd1;
        gap_cnt     <= GW'(FRAME_GAP_CYCLES - 1);
      end else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
endmodule
